mem_arbiter: RTL and testbench

- Shares one single-port RAM between two requesters: the CPU instruction-fetch port (IF) and the CPU load/store port (DATA).
- Sits between riscv_cpu and a unified ram in the SoC top. Both requester ports use a req/ack handshake.
- Fixed priority is DATA over IF, with a streak limit so IF is never starved.
- The arbiter sequences multi-cycle RAM accesses and returns read data with a one-cycle ack pulse.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encodings, default
// widths and counter sizing.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACCESS = 2'd1,
    STATE_ACK    = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Wide enough for RAM_LAT-1 and MAX_DATA_STREAK, both limited to 15.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: DATA wins unless IF is waiting and the DATA streak is spent.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic             d_req,
  input  logic             if_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_d,
  output logic             grant_if
);

  logic streak_full;

  assign streak_full = (streak == CNT_W'(MAX_DATA_STREAK));
  assign grant_d     = d_req && !(if_req && streak_full);
  assign grant_if    = if_req && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU fetch (IF) and load/store (DATA)
// ports, latching the winner at grant and acking with a one-cycle pulse.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   STATE_IDLE   | no transaction; arbitrate and latch the winner
//   STATE_ACCESS | RAM enabled for RAM_LAT cycles, counter counts down
//   STATE_ACK    | one-cycle ack to the winner, requests ignored
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int RAM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int SEL_W = DATA_W/8;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, streak;
  logic [ADDR_W-1:0]  lat_addr;
  logic               lat_we;
  logic [SEL_W-1:0]   lat_sel;
  logic [DATA_W-1:0]  lat_wdata;
  logic               win_d;
  logic [DATA_W-1:0]  if_rdata_q, d_rdata_q;
  logic               grant_d, grant_if, grant;

  mem_arb_pick #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_pick (
    .d_req    (d_req),
    .if_req   (if_req),
    .streak   (streak),
    .grant_d  (grant_d),
    .grant_if (grant_if)
  );

  assign grant = (state == STATE_IDLE) && (grant_d || grant_if);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STATE_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE:   if (grant) state_next = STATE_ACCESS;
      STATE_ACCESS: if (cnt == CNT_ZERO) state_next = STATE_ACK;
      STATE_ACK:    state_next = STATE_IDLE;
      default:      state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= CNT_ZERO;
      streak     <= CNT_ZERO;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_sel    <= '0;
      lat_wdata  <= '0;
      win_d      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (grant) begin
      win_d <= grant_d;
      cnt   <= CNT_W'(RAM_LAT - 1);
      if (grant_d) begin
        lat_addr  <= d_addr;
        lat_we    <= d_we;
        lat_sel   <= d_sel;
        lat_wdata <= d_wdata;
        if (!if_req)
          streak <= CNT_ZERO;
        else if (streak != CNT_W'(MAX_DATA_STREAK))
          streak <= streak + 1'b1;
      end else begin
        // Fetches are always full-word reads.
        lat_addr  <= if_addr;
        lat_we    <= 1'b0;
        lat_sel   <= '1;
        lat_wdata <= '0;
        streak    <= CNT_ZERO;
      end
    end else if (state == STATE_ACCESS) begin
      if (cnt != CNT_ZERO)
        cnt <= cnt - 1'b1;
      else if (win_d)
        d_rdata_q <= lat_we ? '0 : ram_rdata;
      else
        if_rdata_q <= ram_rdata;
    end
  end

  always_comb begin
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    case (state)
      STATE_ACCESS: begin
        ram_ce    = 1'b1;
        ram_we    = lat_we && (cnt == CNT_ZERO);
        ram_addr  = lat_addr;
        ram_sel   = lat_sel;
        ram_wdata = lat_wdata;
      end
      STATE_ACK: begin
        if_ack = !win_d;
        d_ack  = win_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one RAM_LAT=1 instance and one RAM_LAT=3
// instance, read data checked against a scoreboard on every ack.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // RAM_LAT = 1 instance
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_sel = 0;
  logic        if_ack, d_ack, ram_ce, ram_we;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  // RAM_LAT = 3 instance (DATA port only)
  logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
  logic [31:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
  logic [3:0]  b_d_sel = 0;
  logic        b_if_ack, b_d_ack, b_ram_ce, b_ram_we;
  logic [31:0] b_if_rdata, b_d_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_ram_sel;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, b_we_cnt = 0;
  logic [31:0] if_q[$], d_q[$], b_q[$];

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    return (a == 32'h4) ? 32'h0010_0093 : ((a ^ 32'hA5A5_0000) + 32'h11);
  endfunction

  assign ram_rdata   = ram_model(ram_addr);
  assign b_ram_rdata = ram_model(b_ram_addr);

  mem_arbiter #(.RAM_LAT(1), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.RAM_LAT(3), .MAX_DATA_STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_sel(b_d_sel), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .ram_ce(b_ram_ce), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_sel(b_ram_sel),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sel: 0 = IF, 1 = DATA, 2 = DATA on RAM_LAT=3 instance, 3 = either port of dut
  task automatic wait_ack(input int sel, input int maxc, output int lat, output int who);
    who = -1;
    lat = 0;
    while (who < 0 && lat < maxc) begin
      @(negedge clk);
      lat++;
      if ((sel == 0 || sel == 3) && if_ack)      who = 0;
      else if ((sel == 1 || sel == 3) && d_ack)  who = 1;
      else if (sel == 2 && b_d_ack)              who = 2;
    end
    check("ack_seen", 64'(who >= 0), 64'd1);
  endtask

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (b_ram_we) b_we_cnt++;
    if (if_ack || d_ack) check("one_ack_only", 64'(if_ack && d_ack), 64'd0);
    if (if_ack) begin
      check("if_sb_nonempty", 64'(if_q.size() > 0), 64'd1);
      if (if_q.size() > 0) check("if_rdata", 64'(if_rdata), 64'(if_q.pop_front()));
    end
    if (d_ack) begin
      check("d_sb_nonempty", 64'(d_q.size() > 0), 64'd1);
      if (d_q.size() > 0) check("d_rdata", 64'(d_rdata), 64'(d_q.pop_front()));
    end
    if (b_d_ack) begin
      check("b_sb_nonempty", 64'(b_q.size() > 0), 64'd1);
      if (b_q.size() > 0) check("b_d_rdata", 64'(b_d_rdata), 64'(b_q.pop_front()));
    end
    check("b_if_ack_idle", 64'(b_if_ack), 64'd0);
  end

  initial begin
    int lat, who, we0, nz;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({if_ack, d_ack, ram_ce, ram_we}), 64'd0);
    nz = int'(|{ram_addr, ram_wdata, ram_sel, if_rdata, d_rdata});
    check("rst_bus", 64'(nz), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single fetch
    we0 = we_cnt;
    if_addr = 32'h4; if_req = 1'b1;
    if_q.push_back(32'h0010_0093);
    @(negedge clk);
    check("t1_ce", 64'(ram_ce), 64'd1);
    check("t1_addr", 64'(ram_addr), 64'h4);
    check("t1_sel", 64'(ram_sel), 64'hF);
    wait_ack(0, 8, lat, who);
    if_req = 1'b0;
    check("t1_lat", 64'(lat + 1), 64'd2);
    check("t1_no_we", 64'(we_cnt - we0), 64'd0);
    @(negedge clk);

    // 2: simultaneous requests, DATA write wins
    we0 = we_cnt;
    if_addr = 32'h8; if_req = 1'b1;
    d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_sel = 4'hF; d_req = 1'b1;
    d_q.push_back(32'h0);
    if_q.push_back(ram_model(32'h8));
    @(negedge clk);
    check("t2_we", 64'(ram_we), 64'd1);
    check("t2_addr", 64'(ram_addr), 64'h100);
    check("t2_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    check("t2_sel", 64'(ram_sel), 64'hF);
    wait_ack(1, 8, lat, who);
    d_req = 1'b0;
    check("t2_d_lat", 64'(lat + 1), 64'd2);
    wait_ack(0, 8, lat, who);
    if_req = 1'b0;
    check("t2_if_after_d", 64'(lat), 64'd3);
    check("t2_one_we", 64'(we_cnt - we0), 64'd1);
    @(negedge clk);

    // 3: starvation limit, both held high
    d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    if_addr = 32'h80; if_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) if_q.push_back(ram_model(32'h80));
      else            d_q.push_back(ram_model(32'h40));
    end
    for (int k = 0; k < 10; k++) begin
      wait_ack(3, 10, lat, who);
      check($sformatf("t3_order_%0d", k), 64'(who), (k % 5 == 4) ? 64'd0 : 64'd1);
    end
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // 6: IF request dropped during ACCESS
    if_addr = 32'hC; if_req = 1'b1;
    if_q.push_back(ram_model(32'hC));
    @(negedge clk);
    if_req = 1'b0;
    wait_ack(0, 8, lat, who);
    check("t6_lat", 64'(lat), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_idle", 64'({ram_ce, if_ack, d_ack}), 64'd0);
    end

    // 4: RAM_LAT=3 read with address changing during ACCESS
    b_d_we = 1'b0; b_d_addr = 32'h200; b_d_sel = 4'hF; b_d_req = 1'b1;
    b_q.push_back(ram_model(32'h200));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_addr_%0d", i), 64'(b_ram_addr), 64'h200);
      check($sformatf("t4_ctl_%0d", i), 64'({b_ram_ce, b_ram_we, b_d_ack}), 64'b100);
      if (i == 1) b_d_addr = 32'h300;
    end
    wait_ack(2, 4, lat, who);
    b_d_req = 1'b0;
    check("t4_lat", 64'(lat + 3), 64'd4);
    @(negedge clk);

    // 5: asynchronous reset in the middle of a write access
    we0 = b_we_cnt;
    b_d_we = 1'b1; b_d_addr = 32'h104; b_d_wdata = 32'h1234_5678; b_d_req = 1'b1;
    @(negedge clk);
    check("t5_in_access", 64'(b_ram_ce), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ctrl", 64'({b_ram_ce, b_ram_we, b_d_ack, b_if_ack}), 64'd0);
    nz = int'(|{b_ram_addr, b_ram_wdata, b_ram_sel, b_d_rdata, if_rdata, d_rdata});
    check("t5_rst_bus", 64'(nz), 64'd0);
    b_d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_quiet", 64'({b_ram_ce, b_d_ack}), 64'd0);
    end
    check("t5_no_we", 64'(b_we_cnt - we0), 64'd0);
    b_d_we = 1'b0; b_d_addr = 32'h108; b_d_req = 1'b1;
    b_q.push_back(ram_model(32'h108));
    wait_ack(2, 8, lat, who);
    b_d_req = 1'b0;
    check("t5_regrant_lat", 64'(lat), 64'd4);
    repeat (2) @(negedge clk);

    check("sb_drained", 64'(if_q.size() + d_q.size() + b_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
